// File: rtl/button_bank.sv
// Multi-channel button conditioner: synchroniser, shared tick prescaler, per-channel
// debounce FSM with press/release pulses and long-press / auto-repeat events.
module button_bank #(
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned TICK_DIV       = 4096,
  parameter int unsigned DEBOUNCE_TICKS = 2442,
  parameter int unsigned LONG_TICKS     = 24414,
  parameter int unsigned REPEAT_TICKS   = 0,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] button_status,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    S_REL,
    S_CONF_P,
    S_PRESSED,
    S_HELD,
    S_CONF_R
  } state_e;

  logic [N_BTN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  state_e            state_q [N_BTN];
  state_e            state_d [N_BTN];
  logic [CNT_W-1:0]  cnt_q   [N_BTN];
  logic [CNT_W-1:0]  cnt_d   [N_BTN];
  logic [HOLD_W-1:0] hold_q  [N_BTN];
  logic [HOLD_W-1:0] hold_d  [N_BTN];
  logic [HOLD_W-1:0] hold_inc_c [N_BTN];
  logic [N_BTN-1:0]  long_done_q, long_done_d;
  logic [N_BTN-1:0]  status_q, status_d;
  logic [N_BTN-1:0]  press_q, press_d;
  logic [N_BTN-1:0]  release_q, release_d;
  logic [N_BTN-1:0]  long_q, long_d;
  logic [N_BTN-1:0]  raw_c;
  logic              tick_c;

  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    raw_c   = sync2_q ^ {N_BTN{ACTIVE_LOW}};
    tick_c  = (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d   = tick_c ? '0 : pre_q + PRE_W'(1);
  end

  // Saturating hold increment, shared by all pressed-side states.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      hold_inc_c[i] = (hold_q[i] == '1) ? hold_q[i] : hold_q[i] + HOLD_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      hold_d[i]      = hold_q[i];
      long_done_d[i] = long_done_q[i];
      status_d[i]    = status_q[i];
      press_d[i]     = 1'b0;
      release_d[i]   = 1'b0;
      long_d[i]      = 1'b0;
      if (tick_c) begin
        unique case (state_q[i])
          S_REL: begin
            if (raw_c[i]) begin
              if (DEBOUNCE_TICKS <= 1) begin
                state_d[i]     = S_PRESSED;
                status_d[i]    = 1'b1;
                press_d[i]     = 1'b1;
                hold_d[i]      = '0;
                long_done_d[i] = 1'b0;
              end else begin
                state_d[i] = S_CONF_P;
                cnt_d[i]   = CNT_W'(1);
              end
            end
          end
          S_CONF_P: begin
            if (!raw_c[i]) begin
              state_d[i] = S_REL;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_TICKS - 1)) begin
              state_d[i]     = S_PRESSED;
              cnt_d[i]       = '0;
              status_d[i]    = 1'b1;
              press_d[i]     = 1'b1;
              hold_d[i]      = '0;
              long_done_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          S_PRESSED, S_HELD: begin
            hold_d[i] = hold_inc_c[i];
            if (!raw_c[i]) begin
              if (DEBOUNCE_TICKS <= 1) begin
                state_d[i]   = S_REL;
                status_d[i]  = 1'b0;
                release_d[i] = 1'b1;
              end else begin
                state_d[i] = S_CONF_R;
                cnt_d[i]   = CNT_W'(1);
              end
            end else if (state_q[i] == S_PRESSED) begin
              // >= so a threshold crossed while confirming a release still fires here.
              if (hold_inc_c[i] >= HOLD_W'(LONG_TICKS)) begin
                state_d[i]     = S_HELD;
                long_d[i]      = 1'b1;
                long_done_d[i] = 1'b1;
                hold_d[i]      = '0;
              end
            end else if ((REPEAT_TICKS != 0) && (hold_inc_c[i] >= HOLD_W'(REPEAT_TICKS))) begin
              long_d[i] = 1'b1;
              hold_d[i] = '0;
            end
          end
          S_CONF_R: begin
            hold_d[i] = hold_inc_c[i];
            if (raw_c[i]) begin
              state_d[i] = long_done_q[i] ? S_HELD : S_PRESSED;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_TICKS - 1)) begin
              state_d[i]   = S_REL;
              cnt_d[i]     = '0;
              status_d[i]  = 1'b0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = S_REL;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pre_q       <= '0;
      long_done_q <= '0;
      status_q    <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= S_REL;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pre_q       <= pre_d;
      long_done_q <= long_done_d;
      status_q    <= status_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign button_status = status_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: debounce, bounce rejection, long press / repeat,
// release glitches, reset mid-hold and simultaneous channels.
module tb_button_bank;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] button;
  logic [N-1:0] button_status;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;

  int n_tests = 0;
  int n_fail  = 0;
  int press_n [N] = '{default: 0};
  int rel_n   [N] = '{default: 0};
  int long_n  [N] = '{default: 0};
  int overlap_n = 0;

  button_bank #(
    .N_BTN(N), .TICK_DIV(DIV), .DEBOUNCE_TICKS(3),
    .LONG_TICKS(8), .REPEAT_TICKS(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_100MHz(clk),
    .rst_n(rst_n),
    .button(button),
    .button_status(button_status),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Pulse-cycle counters; a stretched or stray pulse shows up in the totals.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (press[i] === 1'b1) press_n[i]++;
      if (release_pulse[i] === 1'b1) rel_n[i]++;
      if (long_press[i] === 1'b1) long_n[i]++;
      if (press[i] === 1'b1 && release_pulse[i] === 1'b1) overlap_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one tick period; returns #1 after the tick edge.
  task automatic tick();
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Press channel ch, hold for last_h ticks after acceptance (pad high on ticks
  // up_after < h <= down_after), then release; exp_long bit h = long_press at tick h.
  task automatic press_cycle(input int ch, input int last_h, input int up_after,
                             input int down_after, input logic [31:0] exp_long);
    logic [N-1:0] oh;
    oh = N'(1) << ch;
    button[ch] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("press ch%0d t%0d", ch, t), 32'(press), (t == 3) ? 32'(oh) : 32'd0);
    end
    chk($sformatf("status_on ch%0d", ch), 32'(button_status), 32'(oh));
    for (int h = 1; h <= last_h; h++) begin
      button[ch] = (h > up_after && h <= down_after);
      tick();
      chk($sformatf("long ch%0d h%0d", ch, h), 32'(long_press), exp_long[h] ? 32'(oh) : 32'd0);
      chk($sformatf("status ch%0d h%0d", ch, h), 32'(button_status), 32'(oh));
      chk($sformatf("rel ch%0d h%0d", ch, h), 32'(release_pulse), 32'd0);
    end
    button[ch] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("release ch%0d t%0d", ch, t), 32'(release_pulse), (t == 3) ? 32'(oh) : 32'd0);
      chk($sformatf("long_off ch%0d t%0d", ch, t), 32'(long_press), 32'd0);
    end
    chk($sformatf("status_off ch%0d", ch), 32'(button_status), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    button = '1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({button_status, press, release_pulse, long_press}), 32'd0);
    rst_n = 1'b1;

    // Clean press/release on channel 0.
    press_cycle(0, 1, 0, 0, 32'h0);

    // Bounce on channel 1: toggling every tick never reaches three stable ticks.
    for (int k = 0; k < 10; k++) begin
      button[1] = k[0];
      tick();
      chk($sformatf("bounce_press k%0d", k), 32'(press), 32'd0);
      chk($sformatf("bounce_status k%0d", k), 32'(button_status), 32'd0);
    end
    button[1] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("bounce_settle t%0d", t), 32'(press), (t == 3) ? 32'h2 : 32'd0);
    end
    button[1] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("bounce_release t%0d", t), 32'(release_pulse), (t == 3) ? 32'h2 : 32'd0);
    end

    // Long press with repeat: events at hold 8, 12, 16.
    press_cycle(0, 17, 0, 0, 32'h0001_1100);
    // One-tick release glitch in HELD: repeat at 12 only, no renewed threshold event.
    press_cycle(0, 13, 9, 10, 32'h0000_1100);
    // Glitch covering the threshold tick: event deferred to tick 10.
    press_cycle(3, 10, 7, 8, 32'h0000_0400);

    // Reset while channel 2 is held.
    button[2] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("rst_press t%0d", t), 32'(press), (t == 3) ? 32'h4 : 32'd0);
    end
    chk("rst_status_before", 32'(button_status), 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({button_status, press, release_pulse, long_press}), 32'd0);
    rst_n = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("rst_repress t%0d", t), 32'(press), (t == 3) ? 32'h4 : 32'd0);
      chk($sformatf("rst_status t%0d", t), 32'(button_status), (t == 3) ? 32'h4 : 32'd0);
    end
    button[2] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("rst_release t%0d", t), 32'(release_pulse), (t == 3) ? 32'h4 : 32'd0);
    end

    // All channels pressed and released together.
    button = '0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("all_press t%0d", t), 32'(press), (t == 3) ? 32'hF : 32'd0);
    end
    chk("all_status", 32'(button_status), 32'hF);
    button = '1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("all_release t%0d", t), 32'(release_pulse), (t == 3) ? 32'hF : 32'd0);
    end
    tick();

    chk("press_total ch0", 32'(press_n[0]), 32'd4);
    chk("press_total ch1", 32'(press_n[1]), 32'd2);
    chk("press_total ch2", 32'(press_n[2]), 32'd3);
    chk("press_total ch3", 32'(press_n[3]), 32'd2);
    chk("rel_total ch0", 32'(rel_n[0]), 32'd4);
    chk("rel_total ch1", 32'(rel_n[1]), 32'd2);
    chk("rel_total ch2", 32'(rel_n[2]), 32'd2);
    chk("rel_total ch3", 32'(rel_n[3]), 32'd2);
    chk("long_total ch0", 32'(long_n[0]), 32'd5);
    chk("long_total ch1", 32'(long_n[1]), 32'd0);
    chk("long_total ch2", 32'(long_n[2]), 32'd0);
    chk("long_total ch3", 32'(long_n[3]), 32'd1);
    chk("press_release_overlap", 32'(overlap_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 The block SHALL expose parameter N_BTN, default 4, number of independent button channels (1..16).
REQ-002 The block SHALL expose parameter TICK_DIV, default 4096, number of clock cycles per sample tick (≈24.4 kHz at 100 MHz).
REQ-003 The block SHALL expose parameter DEBOUNCE_TICKS, default 2442, consecutive stable ticks required to accept a level change (≈0.1 s).
REQ-004 The block SHALL expose parameter LONG_TICKS, default 24414, ticks a press must last before the long-press event fires (≈1 s).
REQ-005 The block SHALL expose parameter REPEAT_TICKS, default 0, auto-repeat interval in ticks after a long press; 0 disables repeat.
REQ-006 The block SHALL expose parameter ACTIVE_LOW, default 1; 1 means a pad level of 0 is "pressed".
REQ-007 The block SHALL have port clk_100MHz, input, width 1: the single system clock; every register is clocked on its rising edge.
REQ-008 The block SHALL have port rst_n, input, width 1: synchronous, active-low reset.
REQ-009 The block SHALL have port button, input, width N_BTN: asynchronous raw pad levels.
REQ-010 The block SHALL have port button_status, output, width N_BTN: debounced level per channel, 1 = pressed.
REQ-011 The block SHALL have port press, output, width N_BTN: one-cycle pulse per channel when a press is accepted.
REQ-012 The block SHALL have port release, output, width N_BTN: one-cycle pulse per channel when a release is accepted.
REQ-013 The block SHALL have port long_press, output, width N_BTN: one-cycle pulse at the long-press threshold and at each auto-repeat.

Function
REQ-014 Each button bit SHALL pass through a 2-flop synchroniser; raw_n = sync_n XOR ACTIVE_LOW (1 = pressed).
REQ-015 One shared prescaler SHALL count 0..TICK_DIV-1 and assert tick for exactly one cycle when it wraps; no derived clocks are used.
REQ-016 Each channel SHALL run an independent FSM with states REL, CONF_P, PRESSED, HELD and CONF_R, a tick counter cnt, a hold counter hold and a flag long_done.
REQ-017 State and counters SHALL update only in tick cycles; pulse outputs are 0 in every other cycle.
REQ-018 In REL with raw=1 at a tick, the FSM SHALL go to CONF_P with cnt=1.
REQ-019 In CONF_P with raw=0, the FSM SHALL return to REL with no pulse.
REQ-020 In CONF_P with raw=1 and cnt=DEBOUNCE_TICKS-1, the FSM SHALL enter PRESSED, set button_status=1, pulse press, and set hold=0 and long_done=0; otherwise it increments cnt.
REQ-021 In PRESSED or HELD, hold SHALL increment every tick, saturating at its maximum; hold width is $clog2(max(LONG_TICKS, REPEAT_TICKS)+1).
REQ-022 In PRESSED, when hold reaches LONG_TICKS, the FSM SHALL pulse long_press, set long_done=1, enter HELD and reset hold to 0.
REQ-023 In HELD with REPEAT_TICKS>0, the FSM SHALL pulse long_press each time hold reaches REPEAT_TICKS and reset hold to 0; with REPEAT_TICKS=0, HELD emits no further pulses.
REQ-024 In PRESSED or HELD with raw=0, the FSM SHALL go to CONF_R with cnt=1 while hold keeps counting.
REQ-025 In CONF_R with raw=1 (bounce), the FSM SHALL return to HELD if long_done=1, else to PRESSED; button_status stays 1 and no pulse is emitted.
REQ-026 In CONF_R with raw=0 and cnt=DEBOUNCE_TICKS-1, the FSM SHALL enter REL, clear button_status and pulse release.
REQ-027 A long_press threshold reached in CONF_R SHALL NOT fire; the hold count is kept, and the event fires on the next tick after returning to PRESSED.
REQ-028 Counter cnt SHALL be $clog2(DEBOUNCE_TICKS+1) bits wide and never wrap.
REQ-029 press and release SHALL never assert in the same cycle for one channel; channels are fully independent and may pulse simultaneously.
REQ-030 DEBOUNCE_TICKS=1 SHALL accept a change at the first tick that sees it.

Reset
REQ-031 While rst_n=0 at a rising edge, all channels SHALL enter REL with cnt, hold, long_done, the prescaler and the synchronisers cleared.
REQ-032 During and after reset, button_status, press, release and long_press SHALL all read 0.
REQ-033 Reset asserted mid-press SHALL emit no release pulse; a button still held after reset SHALL be re-debounced and produce a fresh press.
REQ-034 The first tick after reset SHALL occur TICK_DIV cycles after rst_n is released.

Verification
REQ-035 Clean press: N_BTN=4, TICK_DIV=4, DEBOUNCE_TICKS=3; hold button[0] low -> press[0] pulses once; button_status[0]=1 within 3 tick periods plus 2 sync cycles; others stay 0.
REQ-036 Bounce: toggle button[1] every tick for 10 ticks, then hold it low -> no pulse during toggling; exactly one press after 3 stable ticks.
REQ-037 Long press and repeat: LONG_TICKS=8, REPEAT_TICKS=4, hold 20 ticks -> long_press pulses at hold 8, then at +4 and +8; one release after letting go.
REQ-038 Release bounce: a 1-tick high glitch in HELD -> no release pulse, status stays 1, and no second long_press at the threshold.
REQ-039 Reset mid-hold: drop rst_n while button_status[2]=1 -> all outputs 0 and no release pulse; with the button still held, press[2] fires after the debounce.
REQ-040 Simultaneous: press all 4 channels in the same cycle -> 4 press pulses in the same cycle.
